// File: rtl/processor_pkg.sv
// Shared processor definitions: ROM opcode constants, fetch sequencer states
// and the instruction bundle handed to decode/execute.
package processor_pkg;

    localparam int DATA_WIDTH = 16;

    localparam logic [3:0] ROM_OP_NIBBLE = 4'h3;
    localparam logic [3:0] ROM_DATA_READ = 4'h1;
    localparam logic [7:0] ROM_OP_BYTE   = {ROM_OP_NIBBLE, ROM_DATA_READ};

    localparam logic [DATA_WIDTH-1:0] HALT_OPCODE = 16'h00FF;
    localparam logic [DATA_WIDTH-1:0] RESET_PC    = 16'h0000;
    localparam int                    ROM_DEPTH   = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FCAP,
        S_DREAD,
        S_DCAP,
        S_OUT,
        S_HALTED
    } seq_state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] opcode;
        logic [DATA_WIDTH-1:0] operand;
        logic [DATA_WIDTH-1:0] data;
        logic                  has_data;
        logic [DATA_WIDTH-1:0] pc;
        logic                  err;
    } fetch_bundle_t;

endpackage

// File: rtl/rom_fetch_out_reg.sv
// Output holding register: keeps a bundle stable until the consumer takes it,
// and drops it outright when a redirect makes it stale.
module rom_fetch_out_reg
    import processor_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          discard,
    input  logic          out_ready,
    input  fetch_bundle_t bundle_in,
    output logic          out_valid,
    output fetch_bundle_t bundle_out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            bundle_out    <= '0;
            bundle_out.pc <= RESET_PC;
        end else begin
            if (discard) begin
                out_valid <= 1'b0;
            end else if (load) begin
                out_valid  <= 1'b1;
                bundle_out <= bundle_in;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rom_fetch_sequencer.sv
// Sole master of the program ROM: fetches instruction words, performs the
// optional data read, and hands bundles to decode over valid/ready.
module rom_fetch_sequencer
    import processor_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ROM_DEPTH   = 256,
    parameter logic [7:0]            ROM_OP_BYTE = 8'h31,
    parameter logic [DATA_WIDTH-1:0] HALT_OPCODE = 16'h00FF,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = 16'h0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    input  logic                    redirect_valid,
    input  logic [DATA_WIDTH-1:0]   redirect_addr,
    output logic                    rom_en,
    output logic [DATA_WIDTH-1:0]   rom_addr,
    input  logic [2*DATA_WIDTH-1:0] rom_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_opcode,
    output logic [DATA_WIDTH-1:0]   out_operand,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_has_data,
    output logic [DATA_WIDTH-1:0]   out_pc,
    output logic                    out_err,
    output logic                    halted,
    output logic                    busy
);

    // One extra bit so a depth of 2**DATA_WIDTH never flags an error.
    localparam logic [DATA_WIDTH:0] DEPTH_LIMIT = (DATA_WIDTH+1)'(ROM_DEPTH);

    seq_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] opcode_q, operand_q, data_q;
    logic [DATA_WIDTH-1:0] rom_addr_q;
    logic                  has_data_q, err_q;
    logic                  load, handshake;
    fetch_bundle_t         bundle_in, bundle_out;

    assign handshake = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        rom_en  = 1'b0;
        load    = 1'b0;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH: begin
                rom_en  = 1'b1;
                state_d = S_FCAP;
            end
            S_FCAP: begin
                if (rom_rdata[2*DATA_WIDTH-1 -: 8] == ROM_OP_BYTE) state_d = S_DREAD;
                else                                               state_d = S_OUT;
            end
            S_DREAD: begin
                rom_en  = 1'b1;
                state_d = S_DCAP;
            end
            S_DCAP:   state_d = S_OUT;
            S_OUT: begin
                if (!out_valid) begin
                    load = 1'b1;
                end else if (out_ready) begin
                    if (opcode_q == HALT_OPCODE) state_d = S_HALTED;
                    else if (run)                state_d = S_FETCH;
                    else                         state_d = S_IDLE;
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
        // Redirect beats everything except a parked, stopped sequencer.
        if (redirect_valid) begin
            if (state_q == S_IDLE && !run) state_d = S_IDLE;
            else                           state_d = S_FETCH;
        end
    end

    always_comb begin
        rom_addr = rom_addr_q;
        if (state_q == S_FETCH)      rom_addr = pc_q;
        else if (state_q == S_DREAD) rom_addr = operand_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            opcode_q   <= '0;
            operand_q  <= '0;
            data_q     <= '0;
            has_data_q <= 1'b0;
            err_q      <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (rom_en) rom_addr_q <= rom_addr;
            if (redirect_valid)                   pc_q <= redirect_addr;
            else if (state_q == S_OUT && handshake) pc_q <= pc_q + DATA_WIDTH'(1);
            case (state_q)
                S_FCAP: begin
                    opcode_q   <= rom_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
                    operand_q  <= rom_rdata[DATA_WIDTH-1:0];
                    data_q     <= '0;
                    has_data_q <= 1'b0;
                    err_q      <= ({1'b0, pc_q} >= DEPTH_LIMIT);
                end
                S_DCAP: begin
                    data_q     <= rom_rdata[DATA_WIDTH-1:0];
                    has_data_q <= 1'b1;
                    err_q      <= err_q | ({1'b0, operand_q} >= DEPTH_LIMIT);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bundle_in          = '0;
        bundle_in.opcode   = opcode_q;
        bundle_in.operand  = operand_q;
        bundle_in.data     = data_q;
        bundle_in.has_data = has_data_q;
        bundle_in.pc       = pc_q;
        bundle_in.err      = err_q;
    end

    rom_fetch_out_reg #(
        .RESET_PC (RESET_PC)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .discard    (redirect_valid),
        .out_ready  (out_ready),
        .bundle_in  (bundle_in),
        .out_valid  (out_valid),
        .bundle_out (bundle_out)
    );

    assign out_opcode   = bundle_out.opcode;
    assign out_operand  = bundle_out.operand;
    assign out_data     = bundle_out.data;
    assign out_has_data = bundle_out.has_data;
    assign out_pc       = bundle_out.pc;
    assign out_err      = bundle_out.err;
    assign halted       = (state_q == S_HALTED);
    assign busy         = (state_q != S_IDLE) && (state_q != S_HALTED);

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Bench for rom_fetch_sequencer: ROM model, architectural PC model and
// directed scenarios covering latency, stalls, redirect, halt, wrap and reset.
module tb_rom_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_addr = 16'h0000;
    logic        rom_en;
    logic [15:0] rom_addr;
    logic [31:0] rom_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_opcode, out_operand, out_data, out_pc;
    logic        out_has_data, out_err, halted, busy;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] mem [256];
    logic [15:0] exp_pc;
    logic [31:0] m_word, m_dword;
    logic        m_has;

    always #5 clk = ~clk;

    rom_fetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .rom_en         (rom_en),
        .rom_addr       (rom_addr),
        .rom_rdata      (rom_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_opcode     (out_opcode),
        .out_operand    (out_operand),
        .out_data       (out_data),
        .out_has_data   (out_has_data),
        .out_pc         (out_pc),
        .out_err        (out_err),
        .halted         (halted),
        .busy           (busy)
    );

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return (a < 16'd256) ? mem[a[7:0]] : 32'h0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wait_fetch(input logic [15:0] a, input int budget, input string name);
        int k;
        k = 0;
        while (!(rom_en === 1'b1 && rom_addr === a) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'({rom_en, rom_addr}), 32'({1'b1, a}));
    endtask

    // Synchronous ROM: word available the cycle after the strobe.
    always @(posedge clk)
        if (rom_en === 1'b1) rom_rdata <= rom_word(rom_addr);

    // Architectural PC: redirect loads, an accepted bundle advances by one.
    always @(posedge clk or negedge rst_n)
        if (!rst_n)                       exp_pc <= 16'h0000;
        else if (redirect_valid)          exp_pc <= redirect_addr;
        else if (out_valid && out_ready)  exp_pc <= exp_pc + 16'd1;

    // Every presented bundle must be exactly what the ROM holds at the PC.
    always @(negedge clk) begin
        if (rst_n && out_valid === 1'b1) begin
            m_word  = rom_word(exp_pc);
            m_has   = (m_word[31:24] == 8'h31);
            m_dword = m_has ? rom_word(m_word[15:0]) : 32'h0;
            check("model_pc",       32'(out_pc),       32'(exp_pc));
            check("model_opcode",   32'(out_opcode),   32'(m_word[31:16]));
            check("model_operand",  32'(out_operand),  32'(m_word[15:0]));
            check("model_data",     32'(out_data),     32'(m_dword[15:0]));
            check("model_has_data", 32'(out_has_data), 32'(m_has));
            check("model_err",      32'(out_err),
                  32'((exp_pc >= 16'd256) || (m_has && m_word[15:0] >= 16'd256)));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int bad;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]  = 32'h1200_0005;
        mem[1]  = 32'h3100_0010;
        mem[2]  = 32'h00FF_0000;
        mem[16] = 32'hABCD_1234;
        mem[64] = 32'h4000_0001;
        mem[65] = 32'h00FF_0000;

        repeat (2) @(negedge clk);
        check("rst_valid",  32'(out_valid),  32'd0);
        check("rst_rom_en", 32'(rom_en),     32'd0);
        check("rst_addr",   32'(rom_addr),   32'd0);
        check("rst_halted", 32'(halted),     32'd0);
        check("rst_busy",   32'(busy),       32'd0);
        check("rst_pc",     32'(out_pc),     32'd0);
        check("rst_opcode", 32'(out_opcode), 32'd0);

        run = 1'b1; out_ready = 1'b1; rst_n = 1'b1;
        @(negedge clk);
        check("fetch0", 32'({rom_en, rom_addr}), 32'h1_0000);
        check("fetch0_busy", 32'(busy), 32'd1);
        @(negedge clk); check("lat_plain_c1", 32'(out_valid), 32'd0);
        @(negedge clk); check("lat_plain_c2", 32'(out_valid), 32'd0);
        @(negedge clk); check("lat_plain_c3", 32'(out_valid), 32'd1);
        check("i0_opcode",  32'(out_opcode),   32'h1200);
        check("i0_operand", 32'(out_operand),  32'h0005);
        check("i0_has",     32'(out_has_data), 32'd0);
        check("i0_pc",      32'(out_pc),       32'd0);
        @(negedge clk);
        check("fetch1", 32'({rom_en, rom_addr}), 32'h1_0001);
        check("drop_after_hs", 32'(out_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("dread16", 32'({rom_en, rom_addr}), 32'h1_0010);
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); check("lat_data_c4", 32'(out_valid), 32'd0);
        @(negedge clk); check("lat_data_c5", 32'(out_valid), 32'd1);
        check("i1_opcode", 32'(out_opcode),   32'h3100);
        check("i1_data",   32'(out_data),     32'h1234);
        check("i1_has",    32'(out_has_data), 32'd1);
        check("i1_pc",     32'(out_pc),       32'd1);

        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid !== 1'b1 || rom_en !== 1'b0) bad++;
            @(negedge clk);
        end
        check("stall_hold", 32'(bad), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("fetch2_once", 32'({rom_en, rom_addr}), 32'h1_0002);

        k = 0;
        while (halted !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        check("halt_reached", 32'(halted), 32'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (rom_en !== 1'b0 || halted !== 1'b1 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        check("halt_quiet", 32'(bad), 32'd0);

        redirect_valid = 1'b1; redirect_addr = 16'h0000;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("resume0", 32'({rom_en, rom_addr}), 32'h1_0000);
        check("resume_halted", 32'(halted), 32'd0);

        wait_fetch(16'h0010, 12, "dread16_again");
        redirect_valid = 1'b1; redirect_addr = 16'h0040;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("redir40", 32'({rom_en, rom_addr}), 32'h1_0040);
        check("redir_no_valid", 32'(out_valid), 32'd0);

        k = 0;
        while (halted !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        check("halt2_reached", 32'(halted), 32'd1);

        redirect_valid = 1'b1; redirect_addr = 16'hFFFF;
        @(negedge clk);
        redirect_valid = 1'b0;
        k = 0;
        while (out_valid !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        check("ffff_pc",  32'(out_pc),  32'h0000_FFFF);
        check("ffff_err", 32'(out_err), 32'd1);
        @(negedge clk);
        check("wrap_fetch0", 32'({rom_en, rom_addr}), 32'h1_0000);
        run = 1'b0;

        k = 0;
        while (busy !== 1'b0 && k < 10) begin @(negedge clk); k++; end
        check("runlow_idle",   32'({busy, halted, out_valid}), 32'd0);
        check("runlow_opcode", 32'(out_opcode), 32'h1200);

        redirect_valid = 1'b1; redirect_addr = 16'h0001;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("idle_redir_stay", 32'({busy, rom_en}), 32'd0);
        @(negedge clk);
        check("idle_redir_stay2", 32'({busy, rom_en}), 32'd0);
        run = 1'b1;
        wait_fetch(16'h0001, 4, "idle_redir_fetch");

        @(negedge clk);
        check("fcap_state", 32'({busy, rom_en}), 32'b10);
        run = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_valid",  32'(out_valid),  32'd0);
        check("async_rom_en", 32'(rom_en),     32'd0);
        check("async_busy",   32'(busy),       32'd0);
        check("async_halted", 32'(halted),     32'd0);
        check("async_pc",     32'(out_pc),     32'd0);
        check("async_opcode", 32'(out_opcode), 32'd0);
        check("async_addr",   32'(rom_addr),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_idle", 32'({busy, rom_en, out_valid}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rom_fetch_sequencer.md
Name: rom_fetch_sequencer

Overview:
Sequences every access to the 32-bit program ROM for the 16-bit processor.
- Fetches the instruction word at the PC and splits it into opcode (upper 16 bits) and operand (lower 16 bits).
- For ROM data-read instructions (opcode[15:8] == 8'h31), performs a second ROM access at the operand address and attaches the 16-bit result.
- Presents the bundle to the decode/execute stage over a valid/ready handshake.
- Handles PC increment, branch redirect and halt.
- It is the single ROM access master; no other block drives ROM address or enable.

Parameters:
DATA_WIDTH, 16, width of PC, opcode, operand and data.
ROM_DEPTH, 256, number of valid ROM words; a fetch address >= ROM_DEPTH flags out_err.
ROM_OP_BYTE, 8'h31, opcode[15:8] value identifying a ROM data-read instruction.
HALT_OPCODE, 16'h00FF, full opcode that halts the sequencer after it is delivered.
RESET_PC, 16'h0000, PC value after reset.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  level; 1 = fetching permitted, 0 = stop at next instruction boundary
redirect_valid  input  1  one-cycle pulse: load PC from redirect_addr
redirect_addr  input  16  branch target
rom_en  output  1  ROM access strobe
rom_addr  output  16  ROM word address
rom_rdata  input  32  ROM word; synchronous, valid the cycle after rom_en
out_valid  output  1  instruction bundle valid
out_ready  input  1  consumer accepts bundle
out_opcode  output  16  fetched opcode
out_operand  output  16  fetched operand
out_data  output  16  ROM data for data-read instructions, else 0
out_has_data  output  1  1 when out_data is meaningful
out_pc  output  16  address of delivered instruction
out_err  output  1  fetch or data address >= ROM_DEPTH
halted  output  1  HALTED state indicator
busy  output  1  state is neither IDLE nor HALTED

Behaviour:
- Reset (async, rst_n = 0):
  - State = IDLE, PC = RESET_PC.
  - All outputs 0 except out_pc = RESET_PC.
  - Reset asserted mid-operation abandons any in-flight access immediately.
- States: IDLE, FETCH, FCAP, DREAD, DCAP, OUT, HALTED.
- IDLE:
  - rom_en = 0.
  - If run = 1: go FETCH next cycle.
- FETCH:
  - rom_en = 1, rom_addr = PC.
  - Next state: FCAP.
- FCAP:
  - Register rom_rdata[31:16] into opcode and rom_rdata[15:0] into operand.
  - out_err = (PC >= ROM_DEPTH).
  - If opcode[15:8] == ROM_OP_BYTE: go DREAD. Otherwise: out_data = 0, out_has_data = 0, go OUT.
- DREAD:
  - rom_en = 1, rom_addr = operand.
  - Next state: DCAP.
- DCAP:
  - out_data = rom_rdata[15:0] (the upper half is discarded), out_has_data = 1.
  - out_err |= (operand >= ROM_DEPTH).
  - Next state: OUT.
- OUT:
  - out_valid = 1; bundle held stable until out_valid && out_ready.
  - On handshake, PC <= PC + 1 (16-bit wrap, 16'hFFFF -> 16'h0000). Then:
    - If opcode == HALT_OPCODE: go HALTED.
    - Else if run = 1: go FETCH.
    - Else: go IDLE.
  - out_valid drops the cycle after the handshake.
- HALTED:
  - rom_en = 0, halted = 1.
  - Exit only via redirect or reset.
- Latency:
  - Plain instruction: out_valid asserted 3 cycles after FETCH is entered.
  - Data-read instruction: 5 cycles.
  - Back-to-back throughput with out_ready tied high: one plain instruction per 4 cycles.
- Redirect:
  - In any state other than IDLE with run = 0: PC <= redirect_addr, any partially fetched or undelivered bundle is discarded, out_valid deasserts next cycle, next state = FETCH.
  - In IDLE with run = 0: PC is loaded and the state stays IDLE.
  - Redirect in OUT in the same cycle as a handshake: the handshake completes (consumer received it), redirect wins the PC update (no +1).
  - Redirect overrides HALTED.
- run deassertion mid-fetch does not abort; the current instruction completes delivery, then the sequencer goes to IDLE.
- rom_addr is held at its last value when rom_en = 0 (no X, no tri-state).

Decomposition:
- Shared package processor_pkg holds:
  - DATA_WIDTH and ROM_OP nibble constants (already used by the ROM);
  - ROM_DATA_READ sub-op, HALT_OPCODE;
  - the sequencer state enum;
  - an instruction bundle struct (opcode, operand, data, has_data, pc, err).
- One sub-module is natural: rom_fetch_out_reg, the output holding register implementing the valid/ready hold rule and discard-on-redirect. The FSM and PC logic stay in the top module.

Test Plan:
- Reset, run = 1, ROM[0] = 32'h1200_0005, out_ready = 1 -> rom_addr = 0 in FETCH; out_valid 3 cycles later; opcode 16'h1200, operand 16'h0005, has_data 0, out_pc 0; next fetch at addr 1.
- ROM[1] = 32'h3100_0010, ROM[16] = 32'hABCD_1234 -> second access at addr 16; out_data 16'h1234, has_data 1, latency 5 cycles.
- out_ready held 0 for 6 cycles in OUT -> bundle stable, no further rom_en; accepted on 7th cycle; PC advances once.
- Redirect pulse to 16'h0040 during DREAD -> bundle discarded, no out_valid for it; next rom_addr = 16'h0040.
- ROM[2] = 32'h00FF_0000 delivered -> halted = 1, rom_en stays 0 for 20 cycles; redirect to 16'h0000 -> resumes fetching at 0.
- PC = 16'hFFFF with ROM_DEPTH = 256 -> out_err = 1; after handshake PC wraps to 16'h0000. Separately, assert rst_n = 0 in FCAP -> all outputs clear asynchronously, state IDLE.
